// File: rtl/link_table_arbiter_if.sv
// Bundle between client engines, the link-table controller and the round-robin arbiter.
// The arbiter uses the slave modport; the requesters/controller side uses master.
interface link_table_arbiter_if #(
  parameter int NUM_PORTS     = 4,
  parameter int PORT_ID_WIDTH = 2
);
  // Handshake: a requester holds port_req/port_we stable until it sees a one-cycle
  // port_grant or port_reject, then drops port_req for at least one cycle. The controller
  // answers a one-cycle lt_*_req by raising lt_busy and lowers it when the page op is over.
  logic [NUM_PORTS-1:0]     port_req;
  logic [NUM_PORTS-1:0]     port_we;
  logic [NUM_PORTS-1:0]     port_grant;
  logic [NUM_PORTS-1:0]     port_reject;
  logic [NUM_PORTS-1:0]     port_done;
  logic [NUM_PORTS-1:0]     port_beat;
  logic [PORT_ID_WIDTH-1:0] owner_id;
  logic                     lt_write_req;
  logic                     lt_read_req;
  logic                     lt_busy;
  logic                     lt_beat;
  logic                     data_table_empty;
  logic                     empty_table_empty;
  logic                     timeout_err;

  modport master (
    output port_req, port_we, lt_busy, lt_beat, data_table_empty, empty_table_empty,
    input  port_grant, port_reject, port_done, port_beat, owner_id,
           lt_write_req, lt_read_req, timeout_err
  );

  modport slave (
    input  port_req, port_we, lt_busy, lt_beat, data_table_empty, empty_table_empty,
    output port_grant, port_reject, port_done, port_beat, owner_id,
           lt_write_req, lt_read_req, timeout_err
  );
endinterface

// File: rtl/link_table_arbiter.sv
// Round-robin arbiter sharing one link-table controller among NUM_PORTS page requesters,
// with table-empty screening, start timeout and per-beat strobe routing to the owner.
module link_table_arbiter #(
  parameter int NUM_PORTS      = 4,
  parameter int PORT_ID_WIDTH  = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  link_table_arbiter_if.slave      bus,
  output logic [1:0]               o_dbg_state,
  output logic [PORT_ID_WIDTH-1:0] o_dbg_rr_ptr,
  output logic                     o_dbg_op_we
);
  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_WAIT_START = 2'd1,
    S_WAIT_DONE  = 2'd2
  } state_t;

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t                   r_state;
  logic [PORT_ID_WIDTH-1:0] r_rr_ptr;
  logic [PORT_ID_WIDTH-1:0] r_owner;
  logic                     r_we;
  logic [CNT_W-1:0]         r_cnt;
  logic [NUM_PORTS-1:0]     r_grant;
  logic [NUM_PORTS-1:0]     r_reject;
  logic [NUM_PORTS-1:0]     r_done;
  logic [NUM_PORTS-1:0]     r_beat;
  logic                     r_wr_req;
  logic                     r_rd_req;
  logic                     r_timeout;

  logic                     w_found;
  logic [PORT_ID_WIDTH-1:0] w_win;
  logic                     w_win_we;
  logic                     w_refuse;
  logic [PORT_ID_WIDTH-1:0] w_next_ptr;
  logic [NUM_PORTS-1:0]     w_win_oh;
  logic [NUM_PORTS-1:0]     w_owner_oh;

  // First requesting port at or after r_rr_ptr, wrapping modulo NUM_PORTS.
  always_comb begin : p_search
    int idx;
    idx     = 0;
    w_found = 1'b0;
    w_win   = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      idx = int'(r_rr_ptr) + i;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      if (!w_found && bus.port_req[PORT_ID_WIDTH'(idx)]) begin
        w_found = 1'b1;
        w_win   = PORT_ID_WIDTH'(idx);
      end
    end
  end

  always_comb begin
    w_win_we   = bus.port_we[w_win];
    w_refuse   = w_win_we ? bus.empty_table_empty : bus.data_table_empty;
    w_next_ptr = (int'(w_win) == NUM_PORTS - 1) ? '0 : w_win + 1'b1;
    w_win_oh   = '0;
    w_owner_oh = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_win_oh[i]   = (int'(w_win) == i);
      w_owner_oh[i] = (int'(r_owner) == i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_rr_ptr  <= '0;
      r_owner   <= '0;
      r_we      <= 1'b0;
      r_cnt     <= '0;
      r_grant   <= '0;
      r_reject  <= '0;
      r_done    <= '0;
      r_beat    <= '0;
      r_wr_req  <= 1'b0;
      r_rd_req  <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_grant   <= '0;
      r_reject  <= '0;
      r_done    <= '0;
      r_beat    <= '0;
      r_wr_req  <= 1'b0;
      r_rd_req  <= 1'b0;
      r_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // A busy controller is still draining the previous op, so requests wait.
          if (!bus.lt_busy && w_found) begin
            r_rr_ptr <= w_next_ptr;
            if (w_refuse) begin
              r_reject <= w_win_oh;
            end else begin
              r_grant  <= w_win_oh;
              r_wr_req <= w_win_we;
              r_rd_req <= !w_win_we;
              r_owner  <= w_win;
              r_we     <= w_win_we;
              r_cnt    <= '0;
              r_state  <= S_WAIT_START;
            end
          end
        end
        S_WAIT_START: begin
          if (bus.lt_busy) begin
            r_state <= S_WAIT_DONE;
          end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            r_timeout <= 1'b1;
            r_reject  <= w_owner_oh;
            r_state   <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_WAIT_DONE: begin
          r_beat <= bus.lt_beat ? w_owner_oh : '0;
          if (!bus.lt_busy) begin
            r_done  <= w_owner_oh;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.port_grant   = r_grant;
  assign bus.port_reject  = r_reject;
  assign bus.port_done    = r_done;
  assign bus.port_beat    = r_beat;
  assign bus.owner_id     = r_owner;
  assign bus.lt_write_req = r_wr_req;
  assign bus.lt_read_req  = r_rd_req;
  assign bus.timeout_err  = r_timeout;

  assign o_dbg_state  = r_state;
  assign o_dbg_rr_ptr = r_rr_ptr;
  assign o_dbg_op_we  = r_we;
endmodule

// File: tb/tb_link_table_arbiter.sv
// Bench for link_table_arbiter: a 4-port instance for most scenarios and a 3-port
// instance for the non-power-of-two pointer wrap; grant/reject events are scoreboarded.
module tb_link_table_arbiter;
  localparam int W   = 8;
  localparam int TMO = 64;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  link_table_arbiter_if #(.NUM_PORTS(4), .PORT_ID_WIDTH(2)) bus4 ();
  link_table_arbiter_if #(.NUM_PORTS(3), .PORT_ID_WIDTH(2)) bus3 ();

  logic [1:0] dbg_state4, dbg_state3;
  logic [1:0] dbg_rr4, dbg_rr3;
  logic       dbg_we4, dbg_we3;

  link_table_arbiter #(.NUM_PORTS(4), .PORT_ID_WIDTH(2), .TIMEOUT_CYCLES(TMO)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4),
    .o_dbg_state(dbg_state4), .o_dbg_rr_ptr(dbg_rr4), .o_dbg_op_we(dbg_we4)
  );

  link_table_arbiter #(.NUM_PORTS(3), .PORT_ID_WIDTH(2), .TIMEOUT_CYCLES(TMO)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .bus(bus3),
    .o_dbg_state(dbg_state3), .o_dbg_rr_ptr(dbg_rr3), .o_dbg_op_we(dbg_we3)
  );

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];

  // Event codes: {4'h1, port} = grant, {4'h2, port} = reject.
  function automatic logic [3:0] oh_idx(input logic [3:0] v);
    logic [3:0] r;
    r = 4'hf;
    for (int i = 0; i < 4; i++) if (v[i]) r = 4'(i);
    return r;
  endfunction

  function automatic logic [W-1:0] obs4();
    if (bus4.port_grant != 4'b0)  return {4'h1, oh_idx(bus4.port_grant)};
    if (bus4.port_reject != 4'b0) return {4'h2, oh_idx(bus4.port_reject)};
    return '0;
  endfunction

  function automatic logic [W-1:0] obs3();
    if (bus3.port_grant != 3'b0)  return {4'h1, oh_idx({1'b0, bus3.port_grant})};
    if (bus3.port_reject != 3'b0) return {4'h2, oh_idx({1'b0, bus3.port_reject})};
    return '0;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_idle();
    bus4.port_req = '0; bus4.port_we = '0; bus4.lt_busy = 1'b0; bus4.lt_beat = 1'b0;
    bus4.data_table_empty = 1'b0; bus4.empty_table_empty = 1'b0;
    bus3.port_req = '0; bus3.port_we = '0; bus3.lt_busy = 1'b0; bus3.lt_beat = 1'b0;
    bus3.data_table_empty = 1'b0; bus3.empty_table_empty = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive_idle();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // sel: 0 grant/reject4, 1 done4, 2 timeout4, 3 grant/reject3, 4 done3
  task automatic wait_evt(input int sel, input int max, output int n, output logic hit);
    hit = 1'b0;
    n   = 0;
    for (int i = 1; i <= max && !hit; i++) begin
      tick();
      n = i;
      case (sel)
        0: hit = (bus4.port_grant != 0) || (bus4.port_reject != 0);
        1: hit = (bus4.port_done != 0);
        2: hit = bus4.timeout_err;
        3: hit = (bus3.port_grant != 0) || (bus3.port_reject != 0);
        default: hit = (bus3.port_done != 0);
      endcase
    end
  endtask

  task automatic test_reset();
    logic [20:0] v4;
    logic [17:0] v3;
    rst_n = 1'b0;
    drive_idle();
    bus4.port_req = 4'b1111; bus4.lt_beat = 1'b1; bus3.port_req = 3'b111;
    tick();
    v4 = {bus4.port_grant, bus4.port_reject, bus4.port_done, bus4.port_beat, bus4.owner_id,
          bus4.lt_write_req, bus4.lt_read_req, bus4.timeout_err};
    v3 = {bus3.port_grant, bus3.port_reject, bus3.port_done, bus3.port_beat, bus3.owner_id,
          bus3.lt_write_req, bus3.lt_read_req, bus3.timeout_err};
    total++; if (v4 !== '0) begin bad++; $display("FAIL reset_outputs4: got %h expected 0", v4); end
    total++; if (v3 !== '0) begin bad++; $display("FAIL reset_outputs3: got %h expected 0", v3); end
    total++; if ({dbg_state4, dbg_rr4} !== 4'h0) begin
      bad++; $display("FAIL reset_state_ptr: got %h expected 0", {dbg_state4, dbg_rr4});
    end
    drive_idle();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_page_write();
    int n, beats, other, dones, done_at;
    logic hit;
    logic [3:0] done_val;
    logic [W-1:0] e;
    do_reset();
    bus4.lt_beat = 1'b1;
    tick();
    bus4.lt_beat = 1'b0;
    total++; if (bus4.port_beat !== 4'b0) begin
      bad++; $display("FAIL beat_idle_ignored: got %b expected 0000", bus4.port_beat);
    end
    exp_q.push_back({4'h1, 4'd2});
    bus4.port_we = 4'b0100; bus4.port_req = 4'b0100;
    wait_evt(0, 8, n, hit);
    total++; if (!hit || n != 1) begin bad++; $display("FAIL write_grant_latency: got %0d expected 1", n); end
    e = exp_q.pop_front();
    total++; if (obs4() !== e) begin bad++; $display("FAIL write_grant_event: got %h expected %h", obs4(), e); end
    total++; if (bus4.port_grant !== 4'b0100) begin
      bad++; $display("FAIL write_grant_vec: got %b expected 0100", bus4.port_grant);
    end
    total++; if (bus4.owner_id !== 2'd2) begin bad++; $display("FAIL write_owner: got %0d expected 2", bus4.owner_id); end
    total++; if ({bus4.lt_write_req, bus4.lt_read_req} !== 2'b10) begin
      bad++; $display("FAIL write_req_pulse: got %b expected 10", {bus4.lt_write_req, bus4.lt_read_req});
    end
    total++; if (dbg_state4 !== 2'd1) begin bad++; $display("FAIL write_wait_start: got %0d expected 1", dbg_state4); end
    bus4.port_req = '0;
    bus4.lt_busy  = 1'b1;
    tick();
    beats = 0; other = 0;
    for (int b = 0; b < 16; b++) begin
      bus4.lt_beat = 1'b1;
      tick();
      if (bus4.port_beat[2]) beats++;
      if ((bus4.port_beat & 4'b1011) != 0) other++;
      bus4.lt_beat = 1'b0;
      tick();
      if (bus4.port_beat[2]) beats++;
      if ((bus4.port_beat & 4'b1011) != 0) other++;
    end
    bus4.lt_busy = 1'b0;
    dones = 0; done_at = 0; done_val = '0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (bus4.port_done != 0) begin
        dones++;
        if (done_at == 0) begin done_at = i; done_val = bus4.port_done; end
      end
    end
    total++; if (beats != 16) begin bad++; $display("FAIL beat_count: got %0d expected 16", beats); end
    total++; if (other != 0) begin bad++; $display("FAIL beat_non_owner: got %0d expected 0", other); end
    total++; if (dones != 1 || done_at != 1) begin
      bad++; $display("FAIL done_pulse: got count=%0d at=%0d expected count=1 at=1", dones, done_at);
    end
    total++; if (done_val !== 4'b0100) begin bad++; $display("FAIL done_vec: got %b expected 0100", done_val); end
  endtask

  task automatic test_round_robin();
    int n;
    logic hit;
    logic [3:0] g;
    logic [W-1:0] e;
    do_reset();
    exp_q.push_back({4'h1, 4'd0}); exp_q.push_back({4'h1, 4'd1});
    exp_q.push_back({4'h1, 4'd2}); exp_q.push_back({4'h1, 4'd3});
    exp_q.push_back({4'h1, 4'd0});
    bus4.port_we = 4'b0000; bus4.port_req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_evt(0, 20, n, hit);
      total++; if (!hit || n != 1) begin bad++; $display("FAIL rr_grant_latency%0d: got %0d expected 1", k, n); end
      e = exp_q.pop_front();
      total++; if (obs4() !== e) begin bad++; $display("FAIL rr_order%0d: got %h expected %h", k, obs4(), e); end
      g = bus4.port_grant;
      bus4.port_req = bus4.port_req & ~g;
      bus4.lt_busy  = 1'b1;
      tick();
      tick();
      bus4.lt_busy  = 1'b0;
      bus4.port_req = bus4.port_req | g;
      wait_evt(1, 10, n, hit);
      total++; if (!hit || n != 1) begin bad++; $display("FAIL rr_done%0d: got %0d expected 1", k, n); end
    end
    bus4.port_req = '0;
    tick();
  endtask

  task automatic test_reject_then_grant();
    int n;
    logic hit, rd_seen;
    logic [W-1:0] e;
    do_reset();
    rd_seen = 1'b0;
    bus4.data_table_empty = 1'b1;
    bus4.port_we  = 4'b1000;
    bus4.port_req = 4'b1010;
    exp_q.push_back({4'h2, 4'd1});
    exp_q.push_back({4'h1, 4'd3});
    wait_evt(0, 8, n, hit);
    rd_seen = rd_seen | bus4.lt_read_req;
    total++; if (!hit || n != 1) begin bad++; $display("FAIL reject_latency: got %0d expected 1", n); end
    e = exp_q.pop_front();
    total++; if (obs4() !== e) begin bad++; $display("FAIL read_reject: got %h expected %h", obs4(), e); end
    total++; if (dbg_state4 !== 2'd0) begin bad++; $display("FAIL reject_stays_idle: got %0d expected 0", dbg_state4); end
    bus4.port_req[1] = 1'b0;
    wait_evt(0, 8, n, hit);
    rd_seen = rd_seen | bus4.lt_read_req;
    total++; if (!hit || n != 1) begin bad++; $display("FAIL after_reject_latency: got %0d expected 1", n); end
    e = exp_q.pop_front();
    total++; if (obs4() !== e) begin bad++; $display("FAIL write_after_reject: got %h expected %h", obs4(), e); end
    total++; if (bus4.lt_write_req !== 1'b1) begin bad++; $display("FAIL write_req_p3: got %b expected 1", bus4.lt_write_req); end
    bus4.port_req = '0;
    bus4.lt_busy  = 1'b1;
    tick();
    bus4.lt_busy  = 1'b0;
    wait_evt(1, 8, n, hit);
    total++; if (rd_seen !== 1'b0) begin bad++; $display("FAIL read_req_never: got %b expected 0", rd_seen); end
    bus4.data_table_empty  = 1'b0;
    bus4.empty_table_empty = 1'b1;
    exp_q.push_back({4'h2, 4'd2});
    bus4.port_we  = 4'b0100;
    bus4.port_req = 4'b0100;
    wait_evt(0, 8, n, hit);
    e = exp_q.pop_front();
    total++; if (!hit || obs4() !== e) begin bad++; $display("FAIL write_reject_full: got %h expected %h", obs4(), e); end
    bus4.port_req = '0;
    bus4.empty_table_empty = 1'b0;
    tick();
  endtask

  task automatic test_timeout_and_busy_idle();
    int n;
    logic hit;
    logic [W-1:0] e;
    do_reset();
    exp_q.push_back({4'h1, 4'd0});
    bus4.port_we = 4'b0000; bus4.port_req = 4'b0001;
    wait_evt(0, 8, n, hit);
    e = exp_q.pop_front();
    total++; if (!hit || obs4() !== e) begin bad++; $display("FAIL tmo_grant: got %h expected %h", obs4(), e); end
    bus4.port_req = '0;
    wait_evt(2, TMO + 20, n, hit);
    total++; if (!hit || n != TMO) begin bad++; $display("FAIL timeout_latency: got %0d expected %0d", n, TMO); end
    total++; if (bus4.port_reject !== 4'b0001) begin bad++; $display("FAIL timeout_reject: got %b expected 0001", bus4.port_reject); end
    total++; if (dbg_state4 !== 2'd0) begin bad++; $display("FAIL timeout_idle: got %0d expected 0", dbg_state4); end
    bus4.lt_busy  = 1'b1;
    bus4.port_req = 4'b0010;
    wait_evt(0, 6, n, hit);
    total++; if (hit !== 1'b0) begin bad++; $display("FAIL busy_idle_hold: got event after %0d expected none", n); end
    bus4.lt_busy = 1'b0;
    exp_q.push_back({4'h1, 4'd1});
    wait_evt(0, 4, n, hit);
    e = exp_q.pop_front();
    total++; if (!hit || n != 1 || obs4() !== e) begin
      bad++; $display("FAIL busy_release_grant: got %h at %0d expected %h at 1", obs4(), n, e);
    end
    bus4.port_req = '0;
    bus4.lt_busy  = 1'b1;
    tick();
    bus4.lt_busy  = 1'b0;
    wait_evt(1, 8, n, hit);
  endtask

  task automatic test_three_ports();
    int n;
    logic hit;
    logic [W-1:0] e;
    do_reset();
    exp_q.push_back({4'h1, 4'd2});
    bus3.port_we = 3'b000; bus3.port_req = 3'b100;
    wait_evt(3, 8, n, hit);
    e = exp_q.pop_front();
    total++; if (!hit || n != 1 || obs3() !== e) begin bad++; $display("FAIL p3_grant2: got %h expected %h", obs3(), e); end
    total++; if (dbg_rr3 !== 2'd0) begin bad++; $display("FAIL p3_ptr_wrap: got %0d expected 0", dbg_rr3); end
    bus3.port_req = '0;
    bus3.lt_busy  = 1'b1;
    tick();
    bus3.lt_busy  = 1'b0;
    wait_evt(4, 8, n, hit);
    total++; if (!hit || bus3.port_done !== 3'b100) begin bad++; $display("FAIL p3_done: got %b expected 100", bus3.port_done); end
    exp_q.push_back({4'h1, 4'd0});
    bus3.port_req = 3'b011;
    wait_evt(3, 8, n, hit);
    e = exp_q.pop_front();
    total++; if (!hit || obs3() !== e) begin bad++; $display("FAIL p3_grant0: got %h expected %h", obs3(), e); end
    bus3.port_req = '0;
    bus3.lt_busy  = 1'b1;
    tick();
    bus3.lt_busy  = 1'b0;
    wait_evt(4, 8, n, hit);
  endtask

  task automatic test_reset_mid_op();
    int n, dones;
    logic hit;
    logic [20:0] v4;
    logic [W-1:0] e;
    do_reset();
    exp_q.push_back({4'h1, 4'd2});
    bus4.port_we = 4'b0100; bus4.port_req = 4'b0100;
    wait_evt(0, 8, n, hit);
    e = exp_q.pop_front();
    total++; if (!hit || obs4() !== e) begin bad++; $display("FAIL mid_grant: got %h expected %h", obs4(), e); end
    bus4.port_req = '0;
    bus4.lt_busy  = 1'b1;
    tick();
    total++; if (dbg_state4 !== 2'd2) begin bad++; $display("FAIL mid_wait_done: got %0d expected 2", dbg_state4); end
    bus4.lt_beat = 1'b1;
    tick();
    rst_n = 1'b0;
    #1;
    v4 = {bus4.port_grant, bus4.port_reject, bus4.port_done, bus4.port_beat, bus4.owner_id,
          bus4.lt_write_req, bus4.lt_read_req, bus4.timeout_err};
    total++; if (v4 !== '0 || dbg_state4 !== 2'd0 || dbg_rr4 !== 2'd0) begin
      bad++; $display("FAIL mid_reset_outputs: got %h st=%0d rr=%0d expected 0", v4, dbg_state4, dbg_rr4);
    end
    bus4.lt_busy = 1'b0;
    bus4.lt_beat = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus4.port_done != 0) dones++;
    end
    total++; if (dones != 0) begin bad++; $display("FAIL mid_no_done: got %0d expected 0", dones); end
    exp_q.push_back({4'h1, 4'd0});
    bus4.port_we = 4'b0000; bus4.port_req = 4'b0101;
    wait_evt(0, 8, n, hit);
    e = exp_q.pop_front();
    total++; if (!hit || obs4() !== e) begin bad++; $display("FAIL mid_scan_from0: got %h expected %h", obs4(), e); end
    bus4.port_req = '0;
    bus4.lt_busy  = 1'b1;
    tick();
    bus4.lt_busy  = 1'b0;
    wait_evt(1, 8, n, hit);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    drive_idle();
    @(negedge clk);
    test_reset();
    test_page_write();
    test_round_robin();
    test_reject_then_grant();
    test_timeout_and_busy_idle();
    test_three_ports();
    test_reset_mid_op();
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL queue_drained: got %0d expected 0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/link_table_arbiter.md
# link_table_arbiter

- Round-robin arbiter that shares one link-table controller among `NUM_PORTS` requesters.
- Each requester asks for a whole-page write or read. The arbiter screens each request against the data-table and free-table empty flags, then issues a single-cycle request pulse to the controller.
- It tracks the controller's busy window and routes per-beat strobes back to the owning port.
- It sits between client engines and the link-table controller.

## Interface
Parameters:
- `NUM_PORTS`, 4: number of requesters, 2..16, need not be a power of 2.
- `PORT_ID_WIDTH`, 2: width of `owner_id`, equal to clog2(`NUM_PORTS`).
- `TIMEOUT_CYCLES`, 64: cycles allowed for `lt_busy` to rise after an issue.

Ports (reset `rst_n`, asynchronous, active-low; clock `clk`):
- `clk`  in  1  clock
- `rst_n`  in  1  async active-low reset
- `port_req`  in  NUM_PORTS  level request per port
- `port_we`  in  NUM_PORTS  1 = page write, 0 = page read; valid while `port_req` is high
- `port_grant`  out  NUM_PORTS  1-cycle pulse: op issued
- `port_reject`  out  NUM_PORTS  1-cycle pulse: op refused or timed out
- `port_done`  out  NUM_PORTS  1-cycle pulse: op complete
- `port_beat`  out  NUM_PORTS  `lt_beat` routed to the owner
- `owner_id`  out  PORT_ID_WIDTH  port currently owning the controller
- `lt_write_req`  out  1  1-cycle page-write request to the controller
- `lt_read_req`  out  1  1-cycle page-read request to the controller
- `lt_busy`  in  1  controller not idle
- `lt_beat`  in  1  controller per-beat data strobe
- `data_table_empty`  in  1  no page holds data
- `empty_table_empty`  in  1  no free page
- `timeout_err`  out  1  1-cycle pulse on start timeout

## Operation
- All outputs are registered.
- Reset values: every output is 0, state = IDLE, `rr_ptr` = 0, `owner_id` = 0, timeout counter = 0.

State machine:
- IDLE, only when `lt_busy` = 0: select the first port with `port_req` = 1, scanning from `rr_ptr` upward and wrapping modulo `NUM_PORTS`. Exactly one decision per cycle.
  - Rejection: a read with `data_table_empty` = 1, or a write with `empty_table_empty` = 1, gets a `port_reject` pulse. State stays IDLE.
  - Otherwise the op is issued:
    - pulse `lt_write_req` or `lt_read_req` according to `port_we`;
    - pulse `port_grant`;
    - latch `owner_id` and the op type;
    - clear the timeout counter;
    - go to WAIT_START.
  - After either a reject or an issue, `rr_ptr` = (winner + 1) mod `NUM_PORTS`.
- WAIT_START:
  - `lt_busy` = 1 → WAIT_DONE.
  - Otherwise the counter increments. When it reaches `TIMEOUT_CYCLES`, pulse `timeout_err` and `port_reject[owner]`, then go to IDLE.
- WAIT_DONE:
  - `port_beat[owner]` = `lt_beat`, registered (1-cycle delay). All other `port_beat` bits are 0.
  - `lt_busy` = 0 → pulse `port_done[owner]`, go to IDLE.

Requester rules:
- A requester holds `port_req` and `port_we` stable until it sees its grant or reject.
- It then drops `port_req` for at least 1 cycle.
- Requests from non-owners are ignored outside IDLE and stay pending.

Boundary rules:
- `lt_busy` high while in IDLE (controller still finishing): no issue is made; requests wait.
- `lt_beat` outside WAIT_DONE is ignored.
- A reset asserted mid-op returns everything to reset values immediately. No done or reject pulse is produced. The controller shares the same `rst_n`.

## Timing
- Issue latency: request is seen in IDLE at cycle T → `lt_*_req`, `port_grant` and `owner_id` are valid at T+1. State is WAIT_START from T+1.
- Reject latency: the reject pulse appears at T+1.
- The earliest re-arbitration is the cycle after returning to IDLE.
- Beat latency: 1 cycle from `lt_beat` to `port_beat`.
- Done: `lt_busy` is observed low at cycle D → `port_done` at D+1. The next grant is at D+2 at the earliest.
- Timeout: with no `lt_busy` after issue cycle T+1, `timeout_err` fires at T+1+`TIMEOUT_CYCLES`.

## Test plan
- Port 2 writes. A model controller raises `lt_busy` 1 cycle after `lt_write_req` and runs 16 beats. Required: `port_grant` = 0b0100, `owner_id` = 2, 16 `port_beat[2]` pulses, one `port_done[2]`.
- All 4 ports request reads continuously with the tables non-empty. Required grant order 0, 1, 2, 3, 0, with no port granted twice before the others.
- `data_table_empty` = 1 while port 1 reads and port 3 writes. Required: `port_reject[1]` at T+1, then `port_grant[3]` on the following decision, `lt_read_req` never pulsed.
- `lt_busy` is held 0 after a grant to port 0 with `TIMEOUT_CYCLES` = 64. Required: `timeout_err` and `port_reject[0]` pulse 64 cycles after the grant, and the arbiter is back in IDLE.
- `NUM_PORTS` = 3, with port 2 winning. Required: `rr_ptr` wraps to 0, and port 0 is granted next when ports 0 and 1 both request.
- `rst_n` is pulsed during WAIT_DONE. Required: all outputs 0, no `port_done`, and the next grant starts the scan from port 0.
